// File: rtl/branch_unit_pred.sv
// -----------------------------------------------------------------------------
// branch_unit_pred
//   Branch resolution unit at the execute/writeback boundary.
//   - Keeps a registered flag set (zero, carry, odd, msb, overflow) that is
//     written by flag-setting instructions, with a same-cycle bypass.
//   - Resolves jumps against an extended condition set.
//   - Holds a direct-mapped table of 2-bit saturating counters (BHT) that
//     serves fetch-stage predictions.
//   - On a mispredict it raises a one-cycle registered redirect/flush and
//     squashes the following shadow instruction.
//
// Ports
//   clk, rst        : clock and synchronous active-high reset
//   flag_we         : latch flags from wb_val / c_out / ov this cycle
//   wb_val, c_out, ov : writeback value, ALU carry out, ALU signed overflow
//   jmp, brc, cond  : resolving jump, conditional qualifier, condition code
//   br_pc, br_target, br_pred : jump address, target, fetch prediction
//   fetch_pc        : fetch address for the BHT lookup
//   fetch_pred      : predicted taken for fetch_pc (combinational)
//   jmp_true        : resolved taken (combinational)
//   redirect_valid, redirect_pc : registered redirect / corrected address
//   mispred_cnt     : saturating mispredict counter
// -----------------------------------------------------------------------------
module branch_unit_pred #(
  parameter int WIDTH     = 16,
  parameter int ADDR_W    = 16,
  parameter int BHT_DEPTH = 16,
  localparam int IDX_W    = $clog2(BHT_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flag_we,
  input  logic [WIDTH-1:0]  wb_val,
  input  logic              c_out,
  input  logic              ov,
  input  logic              jmp,
  input  logic              brc,
  input  logic [4:0]        cond,
  input  logic [ADDR_W-1:0] br_pc,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              br_pred,
  input  logic [ADDR_W-1:0] fetch_pc,
  output logic              fetch_pred,
  output logic              jmp_true,
  output logic              redirect_valid,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic [15:0]       mispred_cnt
);

  // Registered state
  logic              zero_r, carry_r, odd_r, msb_r, ovf_r;
  logic [1:0]        bht_r [BHT_DEPTH];
  logic              redirect_valid_r;
  logic [ADDR_W-1:0] redirect_pc_r;
  logic [15:0]       mispred_cnt_r;

  // Combinational signals
  logic              zero_live_s;
  logic              zero_s, carry_s, odd_s, msb_s, ovf_s;
  logic              cond_true_s;
  logic              valid_jmp_s;
  logic              jmp_true_s;
  logic              mispred_s;
  logic [IDX_W-1:0]  br_idx_s;
  logic [IDX_W-1:0]  fetch_idx_s;
  logic [1:0]        br_ctr_s;
  logic [ADDR_W-1:0] fallthrough_pc_s;
  logic              unused_fetch_bits_s;

  assign zero_live_s      = (wb_val == {WIDTH{1'b0}});
  assign br_idx_s         = br_pc[IDX_W-1:0];
  assign fetch_idx_s      = fetch_pc[IDX_W-1:0];
  assign br_ctr_s         = bht_r[br_idx_s];
  assign fallthrough_pc_s = br_pc + {{(ADDR_W-1){1'b0}}, 1'b1};
  // Only the index bits of the fetch address take part in the lookup.
  assign unused_fetch_bits_s = ^fetch_pc;

  // Effective flags: a flag write in the same cycle bypasses the registers.
  always_comb begin
    if (flag_we) begin
      zero_s  = zero_live_s;
      carry_s = c_out;
      odd_s   = wb_val[0];
      msb_s   = wb_val[WIDTH-1];
      ovf_s   = ov;
    end else begin
      zero_s  = zero_r;
      carry_s = carry_r;
      odd_s   = odd_r;
      msb_s   = msb_r;
      ovf_s   = ovf_r;
    end
  end

  // Condition code evaluation; unassigned codes never take.
  always_comb begin
    cond_true_s = 1'b0;
    case (cond)
      5'b00000: cond_true_s = zero_s;
      5'b00001: cond_true_s = ~zero_s;
      5'b00010: cond_true_s = carry_s;
      5'b00011: cond_true_s = ~carry_s;
      5'b00100: cond_true_s = odd_s;
      5'b00101: cond_true_s = ~odd_s;
      5'b00110: cond_true_s = msb_s;
      5'b00111: cond_true_s = ~msb_s;
      5'b01000: cond_true_s = ovf_s;
      5'b01001: cond_true_s = ~ovf_s;
      5'b01010: cond_true_s = msb_s ^ ovf_s;
      5'b01011: cond_true_s = ~(msb_s ^ ovf_s);
      5'b01100: cond_true_s = carry_s & ~zero_s;
      5'b01101: cond_true_s = ~carry_s | zero_s;
      default:  cond_true_s = 1'b0;
    endcase
  end

  // The instruction behind a mispredict is squashed while the redirect is up.
  assign valid_jmp_s = jmp & ~redirect_valid_r;
  assign jmp_true_s  = valid_jmp_s & (~brc | cond_true_s);
  assign mispred_s   = valid_jmp_s & (jmp_true_s != br_pred);

  assign fetch_pred     = bht_r[fetch_idx_s][1];
  assign jmp_true       = jmp_true_s;
  assign redirect_valid = redirect_valid_r;
  assign redirect_pc    = redirect_pc_r;
  assign mispred_cnt    = mispred_cnt_r;

  // Flag register: written on flag_we, independent of squashing.
  always_ff @(posedge clk) begin
    if (rst) begin
      zero_r  <= 1'b0;
      carry_r <= 1'b0;
      odd_r   <= 1'b0;
      msb_r   <= 1'b0;
      ovf_r   <= 1'b0;
    end else if (flag_we) begin
      zero_r  <= zero_live_s;
      carry_r <= c_out;
      odd_r   <= wb_val[0];
      msb_r   <= wb_val[WIDTH-1];
      ovf_r   <= ov;
    end else begin
      zero_r  <= zero_r;
      carry_r <= carry_r;
      odd_r   <= odd_r;
      msb_r   <= msb_r;
      ovf_r   <= ovf_r;
    end
  end

  // BHT: single-cycle reset to weakly not taken, saturating update on
  // resolved conditional jumps only.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BHT_DEPTH; i++) begin
        bht_r[i] <= 2'b01;
      end
    end else if (valid_jmp_s & brc) begin
      if (jmp_true_s) begin
        bht_r[br_idx_s] <= (br_ctr_s == 2'b11) ? 2'b11 : br_ctr_s + 2'b01;
      end else begin
        bht_r[br_idx_s] <= (br_ctr_s == 2'b00) ? 2'b00 : br_ctr_s - 2'b01;
      end
    end else begin
      bht_r[br_idx_s] <= br_ctr_s;
    end
  end

  // Redirect and mispredict counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      redirect_valid_r <= 1'b0;
      redirect_pc_r    <= {ADDR_W{1'b0}};
      mispred_cnt_r    <= 16'h0000;
    end else begin
      redirect_valid_r <= mispred_s;
      if (mispred_s) begin
        redirect_pc_r <= jmp_true_s ? br_target : fallthrough_pc_s;
        mispred_cnt_r <= (mispred_cnt_r == 16'hFFFF) ? 16'hFFFF
                                                     : mispred_cnt_r + 16'h0001;
      end else begin
        redirect_pc_r <= redirect_pc_r;
        mispred_cnt_r <= mispred_cnt_r;
      end
    end
  end

endmodule

// File: tb/tb_branch_unit_pred.sv
// -----------------------------------------------------------------------------
// Testbench for branch_unit_pred: directed scenarios followed by randomized
// traffic, every cycle compared against a behavioural reference model.
// -----------------------------------------------------------------------------
module tb_branch_unit_pred;

  logic        clk = 1'b0;
  logic        rst, flag_we, c_out, ov, jmp, brc, br_pred;
  logic [15:0] wb_val, br_pc, br_target, fetch_pc;
  logic [4:0]  cond;
  logic        fetch_pred, jmp_true, redirect_valid;
  logic [15:0] redirect_pc, mispred_cnt;

  int checks = 0;
  int failures = 0;

  // Reference model state
  bit        z_m, c_m, o_m, m_m, v_m;
  int        bht_m [16];
  bit        rv_m;
  int        rpc_m;
  int        cnt_m;

  always #5 clk = ~clk;

  branch_unit_pred dut (
    .clk(clk), .rst(rst), .flag_we(flag_we), .wb_val(wb_val), .c_out(c_out),
    .ov(ov), .jmp(jmp), .brc(brc), .cond(cond), .br_pc(br_pc),
    .br_target(br_target), .br_pred(br_pred), .fetch_pc(fetch_pc),
    .fetch_pred(fetch_pred), .jmp_true(jmp_true),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .mispred_cnt(mispred_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit cond_ok(input logic [4:0] cc, input bit z, c, o, m, v);
    case (cc)
      5'd0:  return z;
      5'd1:  return !z;
      5'd2:  return c;
      5'd3:  return !c;
      5'd4:  return o;
      5'd5:  return !o;
      5'd6:  return m;
      5'd7:  return !m;
      5'd8:  return v;
      5'd9:  return !v;
      5'd10: return m != v;       // signed less-than
      5'd11: return m == v;       // signed greater-or-equal
      5'd12: return c && !z;      // unsigned greater-than
      5'd13: return !c || z;      // unsigned less-or-equal
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    {z_m, c_m, o_m, m_m, v_m} = 5'b0;
    for (int i = 0; i < 16; i++) bht_m[i] = 1;
    rv_m = 0; rpc_m = 0; cnt_m = 0;
  endtask

  task automatic idle();
    rst = 0; flag_we = 0; wb_val = 16'h0001; c_out = 0; ov = 0;
    jmp = 0; brc = 0; cond = 5'd31; br_pc = 16'h0000; br_target = 16'h0000;
    br_pred = 0;
  endtask

  // One clock: check combinational outputs against the model, advance the
  // model, clock, then check registered outputs.
  task automatic step(input string tag);
    bit z, c, o, m, v, vj, jt, mis;
    int bi;
    #1;
    if (flag_we) begin
      z = (wb_val == 16'h0000); c = c_out; o = wb_val[0]; m = wb_val[15]; v = ov;
    end else begin
      z = z_m; c = c_m; o = o_m; m = m_m; v = v_m;
    end
    vj = jmp && !rv_m;
    jt = vj && (!brc || cond_ok(cond, z, c, o, m, v));
    chk({tag, "_fetch_pred"}, {31'd0, fetch_pred}, {31'd0, bht_m[fetch_pc % 16] >= 2});
    chk({tag, "_jmp_true"}, {31'd0, jmp_true}, {31'd0, jt});
    mis = vj && (jt != br_pred);
    if (rst) begin
      model_reset();
    end else begin
      if (flag_we) begin
        z_m = z; c_m = c; o_m = o; m_m = m; v_m = v;
      end
      if (vj && brc) begin
        bi = br_pc % 16;
        if (jt) bht_m[bi] = (bht_m[bi] < 3) ? bht_m[bi] + 1 : 3;
        else    bht_m[bi] = (bht_m[bi] > 0) ? bht_m[bi] - 1 : 0;
      end
      rv_m = mis;
      if (mis) begin
        rpc_m = jt ? int'(br_target) : (int'(br_pc) + 1) % 65536;
        cnt_m = (cnt_m < 65535) ? cnt_m + 1 : 65535;
      end
    end
    @(posedge clk);
    #1;
    chk({tag, "_redirect_valid"}, {31'd0, redirect_valid}, {31'd0, rv_m});
    chk({tag, "_redirect_pc"}, {16'd0, redirect_pc}, rpc_m);
    chk({tag, "_mispred_cnt"}, {16'd0, mispred_cnt}, cnt_m);
  endtask

  initial begin
    idle();
    rst = 1;
    model_reset();
    @(posedge clk); #1;
    step("reset0");
    step("reset1");
    chk("reset_cnt_const", {16'd0, mispred_cnt}, 32'h0);

    // Taken conditional jump predicted not taken at 0x0003 via flag bypass.
    idle(); fetch_pc = 16'h0003;
    jmp = 1; brc = 1; cond = 5'b00000; wb_val = 16'h0000; flag_we = 1;
    br_pc = 16'h0003; br_target = 16'h1234; br_pred = 0;
    step("tp1");
    chk("tp1_rpc_const", {16'd0, redirect_pc}, 32'h1234);
    chk("tp1_cnt_const", {16'd0, mispred_cnt}, 32'h1);
    idle(); fetch_pc = 16'h0003;
    step("tp1_shadow");
    chk("tp1_fetch_pred_const", {31'd0, fetch_pred}, 32'h1);

    // Saturation and hysteresis at index 5 (br_pred matches, no mispredicts).
    for (int i = 0; i < 3; i++) begin
      idle(); fetch_pc = 16'h0005; jmp = 1; brc = 1; cond = 5'b00001;
      flag_we = 1; wb_val = 16'h0007; br_pc = 16'h0005; br_pred = 1;
      step("tp2_taken");
    end
    for (int i = 0; i < 2; i++) begin
      idle(); fetch_pc = 16'h0005; jmp = 1; brc = 1; cond = 5'b00000;
      flag_we = 1; wb_val = 16'h0007; br_pc = 16'h0005; br_pred = 0;
      step("tp2_not");
    end
    idle(); fetch_pc = 16'h0005;
    step("tp2_final");
    chk("tp2_fetch_pred_const", {31'd0, fetch_pred}, 32'h0);

    // Registered flags from wb_val=0x8000.
    idle(); flag_we = 1; wb_val = 16'h8000; ov = 0;
    step("tp3_set");
    begin
      logic [4:0] cc [4];
      cc[0] = 5'b01010; cc[1] = 5'b00110; cc[2] = 5'b00001; cc[3] = 5'b00000;
      for (int i = 0; i < 4; i++) begin
        idle(); jmp = 1; brc = 1; cond = cc[i]; br_pc = 16'h0009;
        br_pred = (i < 3);
        step("tp3_cond");
      end
    end

    // Not-taken mispredict at 0xFFFF wraps; shadow jump is squashed.
    idle(); jmp = 1; brc = 1; cond = 5'b11111; br_pc = 16'hFFFF; br_pred = 1;
    step("tp4_wrap");
    chk("tp4_rpc_const", {16'd0, redirect_pc}, 32'h0);
    idle(); jmp = 1; brc = 0; br_pc = 16'h0002; br_target = 16'h0040; br_pred = 0;
    step("tp4_shadow");

    // Reset during a redirect cycle.
    idle(); jmp = 1; brc = 0; br_target = 16'h0077; br_pred = 0;
    step("tp5_mis");
    idle(); rst = 1;
    step("tp5_rst");
    for (int i = 0; i < 16; i++) begin
      idle(); fetch_pc = 16'(i);
      step("tp5_bht_lo");
    end
    // One taken resolve per index: a reset value of 01 flips to predict taken.
    for (int i = 0; i < 16; i++) begin
      idle(); jmp = 1; brc = 1; cond = 5'b00000; flag_we = 1; wb_val = 16'h0000;
      br_pc = 16'(i + 32); br_pred = 1;
      step("tp5_bump");
    end
    for (int i = 0; i < 16; i++) begin
      idle(); fetch_pc = 16'(i);
      step("tp5_bht_hi");
    end

    // Counter saturation, starting from a preloaded value near the top.
    idle();
    dut.mispred_cnt_r = 16'hFFFD;
    cnt_m = 65533;
    for (int i = 0; i < 4; i++) begin
      idle(); jmp = 1; brc = 0; br_target = 16'h0100; br_pred = 0;
      step("tp6_mis");
      idle();
      step("tp6_gap");
    end
    chk("tp6_cnt_const", {16'd0, mispred_cnt}, 32'hFFFF);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      rst       = ($urandom_range(0, 99) == 0);
      flag_we   = $urandom_range(0, 1);
      case ($urandom_range(0, 3))
        0: wb_val = 16'h0000;
        1: wb_val = 16'h8000;
        default: wb_val = 16'($urandom);
      endcase
      c_out     = $urandom_range(0, 1);
      ov        = $urandom_range(0, 1);
      jmp       = ($urandom_range(0, 2) != 0);
      brc       = ($urandom_range(0, 3) != 0);
      cond      = 5'($urandom_range(0, 17));
      br_pc     = ($urandom_range(0, 9) == 0) ? 16'hFFFF : 16'($urandom);
      br_target = 16'($urandom);
      br_pred   = $urandom_range(0, 1);
      fetch_pc  = ($urandom_range(0, 1) == 1) ? br_pc : 16'($urandom);
      step("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/branch_unit_pred.md
# branch_unit_pred

Parametrised branch resolution unit for the execute/writeback boundary of the core. Holds a registered flag set (zero, carry, odd, msb, overflow) written by flag-setting instructions and evaluates an extended condition set against it. Carries a direct-mapped 2-bit branch history table (BHT) that serves fetch-stage predictions. On a resolved mispredict it issues a registered redirect/flush to fetch and squashes the following shadow instruction.

## Interface
Parameters:
- WIDTH, 16, datapath width of wb_val
- ADDR_W, 16, instruction address width
- BHT_DEPTH, 16, BHT entries, power of two ≥ 2; IDX_W = log2(BHT_DEPTH)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- flag_we  in  1  latch flags from wb_val/c_out/ov this cycle
- wb_val  in  WIDTH  writeback value
- c_out  in  1  ALU carry out
- ov  in  1  ALU signed overflow
- jmp  in  1  resolving instruction is a jump
- brc  in  1  jump is conditional
- cond  in  5  condition code
- br_pc  in  ADDR_W  address of resolving jump
- br_target  in  ADDR_W  jump target
- br_pred  in  1  prediction fetch made for this jump
- fetch_pc  in  ADDR_W  fetch address for BHT lookup
- fetch_pred  out  1  predicted taken (combinational)
- jmp_true  out  1  resolved taken (combinational)
- redirect_valid  out  1  registered mispredict redirect / flush
- redirect_pc  out  ADDR_W  registered corrected fetch address
- mispred_cnt  out  16  saturating mispredict counter

## Operation
- Flags: Z = (wb_val == 0), C = c_out, O = wb_val[0], M = wb_val[WIDTH-1], V = ov. Registered on flag_we.
- Flag bypass: if flag_we and jmp in same cycle, the condition uses the live values, not the registered ones.
- Conditions: 00000 Z, 00001 !Z, 00010 C, 00011 !C, 00100 O, 00101 !O, 00110 M, 00111 !M, 01000 V, 01001 !V, 01010 M^V (signed lt), 01011 !(M^V) (signed ge), 01100 C&!Z (unsigned gt), 01101 !C|Z (unsigned le). All others evaluate false.
- jmp_true = valid_jmp & (!brc | cond_true); valid_jmp = jmp & !redirect_valid (the shadow instruction is squashed).
- BHT: BHT_DEPTH 2-bit saturating counters indexed by pc[IDX_W-1:0]. fetch_pred = counter[fetch_pc idx][1].
- BHT update only on valid_jmp & brc: taken → +1 saturating at 3; not taken → −1 saturating at 0. Unconditional jumps do not update.
- Mispredict: valid_jmp & (jmp_true != br_pred). Next edge: redirect_valid=1, redirect_pc = jmp_true ? br_target : br_pc+1 (mod 2^ADDR_W), mispred_cnt +1 saturating at 16'hFFFF.
- Unconditional jump with br_pred=0 counts as a mispredict and redirects to br_target.
- Flag updates are not squashed by redirect_valid. Flag writes are owned upstream.

## Timing
- Reset (rst=1 at edge): flags=0, all BHT entries=2'b01 (weakly not taken), redirect_valid=0, redirect_pc=0, mispred_cnt=0. Reset mid-operation discards any pending redirect. Outputs are valid from the next cycle.
- fetch_pred and jmp_true are combinational, zero latency.
- redirect_valid is high for exactly 1 cycle, 1 cycle after the mispredicting resolve. Back-to-back mispredicts cannot occur because the shadow jump is squashed.
- BHT read/write to the same index in the same cycle: fetch_pred returns the pre-update value. The new value is visible the next cycle.
- Flag write: the registered flags are visible to a jmp in the following cycle. A jmp in the same cycle uses the bypass.
- BHT initialisation under reset completes in one cycle; no sequential init walk.

## Test plan
- Reset, then fetch_pc=0x0003 → fetch_pred=0. Conditional jmp at br_pc=0x0003 taken (cond=00000, wb_val=0, flag_we=1), br_pred=0 → jmp_true=1. Next cycle redirect_valid=1, redirect_pc=br_target, mispred_cnt=1, fetch_pred@0x0003=1.
- Three taken resolves at idx 5 → counter saturates at 3. One not-taken → fetch_pred stays 1. A second not-taken → fetch_pred=0.
- Set flags with wb_val=0x8000, ov=0, flag_we, no jmp. Next cycle cond=01010 → taken. cond=00110 → taken. cond=00001 → taken. cond=00000 → not.
- Not-taken mispredict at br_pc=0xFFFF with br_pred=1 → redirect_pc=0x0000 (wrap). A jmp presented in the redirect cycle → jmp_true=0, no BHT update, no count.
- Assert rst during a redirect_valid cycle → all outputs at reset values the next cycle, and the BHT reads 2'b01 at every index.
- Force mispred_cnt to 0xFFFF through repeated mispredicts (or preload in sim) → further mispredicts leave it at 0xFFFF.
